// File: rtl/gray_sync_pkg.sv
// Gray/binary helpers shared by the pointer synchroniser, the FIFO pointer logic and benches.
// Pointers are PTR_W = ADDR_WIDTH+1 bits wide; callers zero-extend to FN_W and truncate the result.
package gray_sync_pkg;

    localparam int FN_W = 32;

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] popcount(input logic [FN_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < FN_W; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain N-flop synchroniser; no logic between stages so it can be constrained as a CDC unit.
module sync_chain #(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchroniser: N-flop chain, registered binary conversion, advance delta
// and an optional checker flagging multi-bit Gray transitions.
module gray_ptr_sync
    import gray_sync_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int STAGES     = 2,
    parameter int CHECK_EN   = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   gray_in,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH:0]   gray_out,
    output logic [ADDR_WIDTH:0]   bin_out,
    output logic                  ptr_adv,
    output logic [ADDR_WIDTH:0]   adv_delta,
    output logic                  gray_err,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be in 2..4");
    end
    if (PTR_W > FN_W) begin : g_bad_width
        $error("gray_ptr_sync: pointer wider than helper functions support");
    end

    logic [PTR_W-1:0] sync_g;
    logic [PTR_W-1:0] cur_bin, prev_bin;
    logic [PTR_W-1:0] prev_g_q, bin_q, delta_q;
    logic             adv_q;

    sync_chain #(.WIDTH(PTR_W), .STAGES(STAGES)) u_chain (
        .clk (clk),
        .rst (rst),
        .d_i (gray_in),
        .q_o (sync_g)
    );

    assign cur_bin  = PTR_W'(gray2bin(FN_W'(sync_g)));
    assign prev_bin = PTR_W'(gray2bin(FN_W'(prev_g_q)));

    // Subtraction wraps naturally, so 127 -> 0 reports an advance of 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_g_q <= '0;
            bin_q    <= '0;
            delta_q  <= '0;
            adv_q    <= 1'b0;
        end else begin
            prev_g_q <= sync_g;
            bin_q    <= cur_bin;
            delta_q  <= cur_bin - prev_bin;
            adv_q    <= (sync_g != prev_g_q);
        end
    end

    assign gray_out  = sync_g;
    assign bin_out   = bin_q;
    assign ptr_adv   = adv_q;
    assign adv_delta = delta_q;

    if (CHECK_EN != 0) begin : g_check
        logic                 multi_bit;
        logic                 err_q, err_d;
        logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

        assign multi_bit = popcount(FN_W'(sync_g ^ prev_g_q)) > 6'd1;

        // A fresh error beats a simultaneous clear so no event is lost.
        always_comb begin
            err_d = err_q;
            cnt_d = cnt_q;
            if (multi_bit) begin
                err_d = 1'b1;
                if (err_clr) begin
                    cnt_d = ERR_CNT_W'(1);
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (err_clr) begin
                err_d = 1'b0;
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                err_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                err_q <= err_d;
                cnt_q <= cnt_d;
            end
        end

        assign gray_err = err_q;
        assign err_cnt  = cnt_q;
    end else begin : g_no_check
        logic unused_err_clr;
        assign unused_err_clr = err_clr;
        assign gray_err = 1'b0;
        assign err_cnt  = '0;
    end

endmodule

// File: doc/gray_ptr_sync.md
Name: gray_ptr_sync

Overview:
Parametrised successor to the two-flop pointer synchroniser used in the async FIFO. It carries a Gray-coded FIFO pointer through a configurable N-flop chain into the local clock domain and converts it to binary. It also reports per-cycle pointer advance and flags illegal multi-bit Gray transitions, which indicate metastability-corrupted or mis-encoded pointers. It sits on both the wptr→rclk and rptr→wclk paths of the FIFO.

Parameters:
ADDR_WIDTH, 6, FIFO address width; pointers are ADDR_WIDTH+1 bits (extra wrap bit).
STAGES, 2, number of synchroniser flops; legal 2..4; any other value is an elaboration-time error.
CHECK_EN, 1, 1 = Gray-transition checker and error counter active; 0 = err outputs tied to 0, checker logic removed.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  local-domain clock.
rst  in  1  synchronous active-high reset.
gray_in  in  ADDR_WIDTH+1  Gray pointer from the foreign domain; asynchronous to clk.
err_clr  in  1  clears sticky error flag and error counter.
gray_out  out  ADDR_WIDTH+1  synchronised Gray pointer.
bin_out  out  ADDR_WIDTH+1  binary form of the synchronised pointer, registered.
ptr_adv  out  1  one-cycle pulse when gray_out differed from its previous value.
adv_delta  out  ADDR_WIDTH+1  binary advance since the previous sample, modulo 2^(ADDR_WIDTH+1).
gray_err  out  1  sticky flag: a synchronised transition changed more than one bit.
err_cnt  out  ERR_CNT_W  saturating count of illegal transitions.

Behaviour:
- Reset: on a rising clk edge with rst=1, every flop clears. All outputs are 0 on the cycle after that edge. Reset mid-operation discards in-flight samples, and the checker does not flag the first post-reset transition relative to 0 unless it is itself multi-bit.
- Chain: s[0] <= gray_in; s[i] <= s[i-1]; gray_out = s[STAGES-1]. Latency from gray_in to gray_out is STAGES cycles. There is no logic between chain flops.
- Stage 2 registers, updated every cycle from gray_out:
  - bin_out <= gray2bin(gray_out). Latency is STAGES+1 from gray_in.
  - prev_g <= gray_out.
  - ptr_adv <= (gray_out != prev_g).
  - adv_delta <= gray2bin(gray_out) - gray2bin(prev_g), truncated to ADDR_WIDTH+1 bits. Wrap 127→0 gives delta 1. No change gives delta 0.
  - ptr_adv, adv_delta and bin_out are mutually aligned on the same cycle.
- Checker (CHECK_EN=1), with hd = popcount(gray_out ^ prev_g):
  - If hd > 1: gray_err <= 1 and err_cnt <= err_cnt+1. err_cnt saturates at all-ones and does not wrap.
  - Error outputs align with ptr_adv.
  - err_clr alone: gray_err <= 0 and err_cnt <= 0.
  - err_clr and a new error on the same cycle: error wins, so gray_err=1 and err_cnt=1.
  - rst overrides err_clr.
- Multi-cycle jumps: hd=1 per sample is legal even if the foreign pointer advanced several steps between samples. This is normal for a slow destination clock, and adv_delta reports the multi-step advance.
- CHECK_EN=0: gray_err=0 and err_cnt=0 constantly. All other behaviour is identical.

Decomposition:
- Package gray_sync_pkg:
  - function gray2bin(param width via ADDR_WIDTH) and function bin2gray (the latter is used by the bench and the FIFO pointer logic).
  - function popcount for the checker.
  - localparam PTR_W = ADDR_WIDTH+1 pattern documented for users.
- Sub-module sync_chain (WIDTH, STAGES): plain flop chain with synchronous active-high reset. Kept separate so the chain can carry a synthesis/CDC attribute and be constrained as a unit.
- gray_ptr_sync instantiates sync_chain and holds the conversion, delta and checker registers.

Test Plan:
1. Reset/latency, STAGES=2: after reset, drive gray_in=bin2gray(5)=7 and hold. gray_out=7 at +2 cycles; bin_out=5, ptr_adv=1 and adv_delta=5 at +3 cycles; ptr_adv=0 at +4 cycles.
2. Incrementing pointer: gray_in steps bin2gray(0..130), one step per clk. ptr_adv=1 every cycle with adv_delta=1, including the 127→0 wrap (gray 64→0). gray_err stays 0.
3. Slow sampling: change gray_in bin 10→13 between samples via legal one-bit steps held one cycle each, then hold. Check that adv_delta accumulates to 3 total, with no error.
4. Illegal jump: hold 0, then drive gray 0→3 (2 bits). gray_err=1 and err_cnt=1 at +3 cycles. Repeat 300 times; err_cnt saturates at 255.
5. Clear collision: assert err_clr on the same cycle a new illegal transition is checked. Result is gray_err=1 and err_cnt=1. err_clr alone next cycle gives 0/0.
6. Mid-operation reset and mode: assert rst while gray_out=bin2gray(40); all outputs are 0 next cycle. Rerun scenario 4 with CHECK_EN=0 and STAGES=4: no error flags, and gray_out latency is 4 cycles.
